// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C controller arbiter.
package i2c_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    REPORT
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(ptr_i) + k) % N_REQ);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        found       = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/i2c_cont_arbiter.sv
// Round-robin front end sharing one I2C controller between N_REQ requesters,
// with per-transaction timeout supervision and done/err reporting.
module i2c_cont_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int TO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic                    timeout,
  output logic                    busy,
  output logic                    cont_start,
  output logic                    cont_rw,
  output logic [ADDR_W-1:0]       cont_address,
  output logic [DATA_W-1:0]       cont_data_in,
  input  logic                    cont_ready,
  input  logic                    cont_error
);

  localparam int            PW     = $clog2(N_REQ);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;
  logic                errf_q, errf_d;
  logic                tof_q, tof_d;

  logic [N_REQ-1:0]    arb_gnt;
  logic [PW-1:0]       arb_idx;
  logic                arb_valid;
  logic [TO_W-1:0]     cnt_inc;
  logic                report;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Saturating so a stuck wait never wraps back below the limit.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    errf_d  = errf_q;
    tof_d   = tof_q;
    case (state_q)
      IDLE: begin
        if (arb_valid && cont_ready) begin
          gnt_d   = arb_gnt;
          gidx_d  = arb_idx;
          rw_d    = req_rw[arb_idx];
          addr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
          data_d  = req_data[arb_idx*DATA_W +: DATA_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        errf_d  = 1'b0;
        tof_d   = 1'b0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!cont_ready) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q >= TO_MAX) begin
          tof_d   = 1'b1;
          state_d = REPORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (cont_ready) begin
          errf_d  = cont_error;
          state_d = REPORT;
        end else if (cnt_q >= TO_MAX) begin
          tof_d   = 1'b1;
          state_d = REPORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REPORT: begin
        ptr_d   = gidx_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N_REQ - 1);
      gidx_q  <= '0;
      gnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      errf_q  <= 1'b0;
      tof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      errf_q  <= errf_d;
      tof_q   <= tof_d;
    end
  end

  // Status pulses decode straight from state so reset clears them at once.
  assign report       = (state_q == REPORT);
  assign gnt          = gnt_q;
  assign done         = report ? gnt_q : '0;
  assign err          = (report && (errf_q || tof_q)) ? gnt_q : '0;
  assign timeout      = report && tof_q;
  assign busy         = (state_q != IDLE);
  assign cont_start   = (state_q == ISSUE);
  assign cont_rw      = rw_q;
  assign cont_address = addr_q;
  assign cont_data_in = data_q;

endmodule

// File: tb/tb_i2c_cont_arbiter.sv
// Self-checking bench: cycle-timed transaction model plus directed and random stimulus.
module tb_i2c_cont_arbiter;
  localparam int N  = 4;
  localparam int TO = 50;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   req_rw;
  logic [N*8-1:0] req_addr;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   gnt, done, err;
  logic           timeout, busy, cont_start, cont_rw;
  logic [7:0]     cont_address, cont_data_in;
  logic           cont_ready, cont_error;

  i2c_cont_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data), .gnt(gnt), .done(done), .err(err), .timeout(timeout),
    .busy(busy), .cont_start(cont_start), .cont_rw(cont_rw),
    .cont_address(cont_address), .cont_data_in(cont_data_in),
    .cont_ready(cont_ready), .cont_error(cont_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Controller stand-in: drops ready right after start, raises it ctrl_lat cycles later.
  int ctrl_lat = 20;
  bit ctrl_err = 1'b0, ctrl_hang = 1'b0, ctrl_force_low = 1'b0;
  int ccnt;
  initial begin
    cont_ready = 1'b1;
    cont_error = 1'b0;
    ccnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cont_ready = 1'b1; cont_error = 1'b0; ccnt = 0;
      end else if (ctrl_force_low) begin
        cont_ready = 1'b0;
      end else if (cont_start && !ctrl_hang) begin
        cont_ready = 1'b0; ccnt = ctrl_lat;
      end else if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin cont_ready = 1'b1; cont_error = ctrl_err; end
      end else begin
        cont_ready = 1'b1;
      end
    end
  end

  // Reference model: a transaction is described by its issue cycle, the cycle
  // the controller went busy, and the cycle it is reported.
  int m_cyc = 0, m_ptr = N - 1, m_w = 0, m_issue = 0, m_drop = -1, m_rep = -1;
  bit m_act = 1'b0, m_to = 1'b0, m_er = 1'b0;
  logic       m_rw = 1'b0;
  logic [7:0] m_addr = '0, m_data = '0;
  logic [N-1:0] e_gnt = '0, e_done = '0, e_err = '0;
  logic e_to = 1'b0, e_busy = 1'b0, e_start = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_act = 1'b0; m_ptr = N - 1; m_rw = 1'b0; m_addr = '0; m_data = '0;
      e_gnt = '0; e_done = '0; e_err = '0; e_to = 1'b0; e_busy = 1'b0; e_start = 1'b0;
    end else begin
      int c;
      c = m_cyc;
      if (!m_act) begin
        if (req != '0 && cont_ready) begin
          m_w = -1;
          for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_w < 0 && req[j]) m_w = j;
          end
          m_act = 1'b1; m_issue = c + 1; m_drop = -1; m_rep = -1;
          m_to = 1'b0; m_er = 1'b0;
          m_rw = req_rw[m_w]; m_addr = req_addr[8*m_w +: 8]; m_data = req_data[8*m_w +: 8];
        end
      end else if (m_rep == c) begin
        m_act = 1'b0; m_ptr = m_w;
      end else if (c > m_issue && m_rep < 0) begin
        if (m_drop < 0) begin
          if (!cont_ready) m_drop = c;
          else if (c - (m_issue + 1) >= TO) begin m_rep = c + 1; m_to = 1'b1; m_er = 1'b1; end
        end else begin
          if (cont_ready) begin m_rep = c + 1; m_er = cont_error; end
          else if (c - (m_drop + 1) >= TO) begin m_rep = c + 1; m_to = 1'b1; m_er = 1'b1; end
        end
      end
      m_cyc = c + 1;
      e_busy  = m_act;
      e_gnt   = m_act ? (N'(1) << m_w) : '0;
      e_start = m_act && (m_cyc == m_issue);
      e_done  = (m_act && m_cyc == m_rep) ? e_gnt : '0;
      e_err   = m_er ? e_done : '0;
      e_to    = m_to && (e_done != '0);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("timeout", 32'(timeout), 32'(e_to));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cont_start", 32'(cont_start), 32'(e_start));
    chk("cont_rw", 32'(cont_rw), 32'(m_rw));
    chk("cont_address", 32'(cont_address), 32'(m_addr));
    chk("cont_data_in", 32'(cont_data_in), 32'(m_data));
  end

  task automatic wait_start(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (cont_start) begin ok = 1'b1; break; end
    end
    if (!ok) chk({nm, "_start_seen"}, 0, 1);
  endtask

  task automatic wait_done(input string nm, input int idx, output int dly);
    dly = -1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (done[idx]) begin dly = i; break; end
    end
    if (dly < 0) chk({nm, "_done_seen"}, 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_reached", 0, 1);
  endtask

  initial begin
    bit ok;
    int dly;
    rst = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(cont_start), 0);
    #2 rst = 1'b1;

    // Round-robin with all four requesting: 0x10..0x13 then back to 0x10.
    @(negedge clk);
    ctrl_lat = 2;
    for (int i = 0; i < N; i++) req_addr[8*i +: 8] = 8'(8'h10 + i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start("rr", ok);
      chk("rr_addr", 32'(cont_address), 32'(8'h10 + (k % 4)));
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
    end
    req = '0;
    wait_idle(100);

    // Single write to requester 0.
    @(negedge clk);
    ctrl_lat = 20; ctrl_err = 1'b0;
    req_rw[0] = 1'b0; req_addr[7:0] = 8'h50; req_data[7:0] = 8'hA5; req = 4'b0001;
    wait_start("wr", ok);
    chk("wr_addr", 32'(cont_address), 32'h50);
    chk("wr_data", 32'(cont_data_in), 32'hA5);
    wait_done("wr", 0, dly);
    chk("wr_start_one_cycle", 32'(dly > 1), 1);
    chk("wr_latency", 32'(dly), 21);
    chk("wr_err", 32'(err), 0);
    req = '0;
    wait_idle(10);

    // NACK from requester 2.
    @(negedge clk);
    ctrl_lat = 5; ctrl_err = 1'b1;
    req_addr[23:16] = 8'h7F; req = 4'b0100;
    wait_done("nack", 2, dly);
    chk("nack_err", 32'(err), 32'h4);
    chk("nack_timeout", 32'(timeout), 0);
    req = '0; ctrl_err = 1'b0;
    wait_idle(10);

    // Controller never goes busy: timeout abort, then a normal request.
    @(negedge clk);
    ctrl_hang = 1'b1; req = 4'b0010;
    wait_start("to", ok);
    wait_done("to", 1, dly);
    chk("to_latency", 32'(dly), 52);
    chk("to_err", 32'(err), 32'h2);
    chk("to_flag", 32'(timeout), 1);
    req = '0; ctrl_hang = 1'b0;
    wait_idle(10);
    @(negedge clk);
    ctrl_lat = 3; req = 4'b0010;
    wait_done("after_to", 1, dly);
    chk("after_to_flag", 32'(timeout), 0);
    req = '0;
    wait_idle(10);

    // Ready held low at request time: no grant until it recovers.
    @(negedge clk);
    ctrl_force_low = 1'b1;
    repeat (2) @(negedge clk);
    req_addr[31:24] = 8'h33; req = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rdylow_gnt", 32'(gnt), 0);
      chk("rdylow_start", 32'(cont_start), 0);
    end
    ctrl_force_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      if (cont_ready) begin ok = 1'b1; break; end
    end
    chk("rdylow_recover", 32'(ok), 1);
    @(negedge clk);
    chk("rdylow_issue", 32'(cont_start), 1);
    chk("rdylow_gnt3", 32'(gnt), 32'h8);
    wait_done("rdylow", 3, dly);
    req = '0;
    wait_idle(10);

    // Asynchronous reset while waiting for completion.
    @(negedge clk);
    ctrl_lat = 30; req = 4'b0100;
    wait_start("ar", ok);
    repeat (5) @(negedge clk);
    chk("ar_busy_before", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_start", 32'(cont_start), 0);
    chk("ar_done", 32'(done), 0);
    req = '0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    ctrl_lat = 2;
    for (int i = 0; i < N; i++) req_addr[8*i +: 8] = 8'(8'hA0 + i);
    req = 4'b1111;
    wait_start("ar_first", ok);
    chk("ar_first_addr", 32'(cont_address), 32'hA0);
    chk("ar_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    wait_idle(20);

    // Random traffic: requesters hold until their done; controller timing varies.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      ctrl_lat  = ($urandom_range(0, 19) == 0) ? 60 : int'($urandom_range(1, 8));
      ctrl_err  = ($urandom_range(0, 3) == 0);
      ctrl_hang = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_rw[i] = 1'($urandom_range(0, 1));
          req_addr[8*i +: 8] = 8'($urandom);
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req[i] && !gnt[i] && $urandom_range(0, 59) == 0) req[i] = 1'b0;
      end
    end
    req = '0; ctrl_hang = 1'b0;
    wait_idle(300);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
